// File: rtl/csr_row_fetch.sv
// csr_row_fetch
//   Walks a CSR-encoded feature matrix H row by row and assembles one dense
//   row packet per row (column indices, values, row info) zero-padded to
//   DOT_PRODUCT_SIZE slots. Each packet is presented on a valid/ready
//   handshake; done_o pulses once after the last row is accepted.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   start_i           begin fetching rows 0..H_NUM_OF_ROWS-1 (IDLE only)
//   info_rd_o/addr_o  row-info memory read port (synchronous, 1-cycle latency)
//   info_i            row-info word: [W-1:1] row length, [0] source-node flag
//   elem_rd_o/addr_o  element memory read port (synchronous, 1-cycle latency)
//   elem_col_idx_i    element column index
//   elem_value_i      element value
//   row_valid_o       packet valid
//   row_ready_i       consumer accepts packet
//   row_col_idx_o     per-slot column indices
//   row_value_o       per-slot values
//   row_info_o        saturated row length + source-node flag
//   row_idx_o         index of the presented row
//   done_o            one-cycle pulse after the last handshake
//   len_err_o         sticky: a row length exceeded DOT_PRODUCT_SIZE
module csr_row_fetch #(
    parameter int DATA_WIDTH       = 8,
    parameter int DOT_PRODUCT_SIZE = 5,
    parameter int H_NUM_OF_ROWS    = 5,
    parameter int NNZ_DEPTH        = 64,
    parameter int COL_IDX_WIDTH    = $clog2(DOT_PRODUCT_SIZE),
    parameter int ROW_LEN_WIDTH    = $clog2(DOT_PRODUCT_SIZE + 1),
    parameter int ROW_INFO_WIDTH   = ROW_LEN_WIDTH + 1,
    parameter int NNZ_ADDR_W       = $clog2(NNZ_DEPTH),
    parameter int ROW_ADDR_W       = $clog2(H_NUM_OF_ROWS)
) (
    input  logic                                              clk,
    input  logic                                              rst_n,
    input  logic                                              start_i,
    output logic                                              info_rd_o,
    output logic [ROW_ADDR_W-1:0]                             info_addr_o,
    input  logic [ROW_INFO_WIDTH-1:0]                         info_i,
    output logic                                              elem_rd_o,
    output logic [NNZ_ADDR_W-1:0]                             elem_addr_o,
    input  logic [COL_IDX_WIDTH-1:0]                          elem_col_idx_i,
    input  logic [DATA_WIDTH-1:0]                             elem_value_i,
    output logic                                              row_valid_o,
    input  logic                                              row_ready_i,
    output logic [0:DOT_PRODUCT_SIZE-1][COL_IDX_WIDTH-1:0]    row_col_idx_o,
    output logic [0:DOT_PRODUCT_SIZE-1][DATA_WIDTH-1:0]       row_value_o,
    output logic [ROW_INFO_WIDTH-1:0]                         row_info_o,
    output logic [ROW_ADDR_W-1:0]                             row_idx_o,
    output logic                                              done_o,
    output logic                                              len_err_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INFO,
        S_INFO_CAP,
        S_ELEM,
        S_ELEM_TAIL,
        S_OUT,
        S_DONE
    } state_t;

    localparam logic [ROW_LEN_WIDTH-1:0] MAX_LEN  = ROW_LEN_WIDTH'(DOT_PRODUCT_SIZE);
    localparam logic [ROW_ADDR_W-1:0]    LAST_ROW = ROW_ADDR_W'(H_NUM_OF_ROWS - 1);

    state_t state;
    state_t state_next;

    logic [ROW_ADDR_W-1:0]                          row_cnt;
    logic [NNZ_ADDR_W-1:0]                          ptr;
    logic [ROW_LEN_WIDTH-1:0]                       len_raw;     // unsaturated length, drives read count
    logic [ROW_LEN_WIDTH-1:0]                       issue_cnt;
    logic [ROW_LEN_WIDTH-1:0]                       cap_cnt;
    logic                                           rd_d;        // element data arrives this cycle
    logic                                           len_err;
    logic [ROW_INFO_WIDTH-1:0]                      row_info_q;
    logic [0:DOT_PRODUCT_SIZE-1][COL_IDX_WIDTH-1:0] slot_col;
    logic [0:DOT_PRODUCT_SIZE-1][DATA_WIDTH-1:0]    slot_val;

    logic [ROW_LEN_WIDTH-1:0] info_len;
    logic [ROW_LEN_WIDTH-1:0] info_len_sat;

    assign info_len     = info_i[ROW_INFO_WIDTH-1:1];
    assign info_len_sat = (info_len > MAX_LEN) ? MAX_LEN : info_len;

    assign info_addr_o   = row_cnt;
    assign elem_addr_o   = ptr;
    assign row_idx_o     = row_cnt;
    assign row_info_o    = row_info_q;
    assign row_col_idx_o = slot_col;
    assign row_value_o   = slot_val;
    assign len_err_o     = len_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        info_rd_o   = 1'b0;
        elem_rd_o   = 1'b0;
        row_valid_o = 1'b0;
        done_o      = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start_i) begin
                    state_next = S_INFO;
                end
            end
            S_INFO: begin
                info_rd_o  = 1'b1;
                state_next = S_INFO_CAP;
            end
            S_INFO_CAP: begin
                state_next = (info_len == '0) ? S_OUT : S_ELEM;
            end
            S_ELEM: begin
                elem_rd_o = 1'b1;
                if (issue_cnt == len_raw - ROW_LEN_WIDTH'(1)) begin
                    state_next = S_ELEM_TAIL;
                end
            end
            S_ELEM_TAIL: begin
                state_next = S_OUT;
            end
            S_OUT: begin
                row_valid_o = 1'b1;
                if (row_ready_i) begin
                    state_next = (row_cnt == LAST_ROW) ? S_DONE : S_INFO;
                end
            end
            S_DONE: begin
                done_o     = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_cnt    <= '0;
            ptr        <= '0;
            len_raw    <= '0;
            issue_cnt  <= '0;
            cap_cnt    <= '0;
            rd_d       <= 1'b0;
            len_err    <= 1'b0;
            row_info_q <= '0;
            slot_col   <= '0;
            slot_val   <= '0;
        end else begin
            rd_d <= (state == S_ELEM);

            if (state == S_IDLE && start_i) begin
                row_cnt    <= '0;
                ptr        <= '0;
                len_err    <= 1'b0;
                row_info_q <= '0;
            end

            // Every row starts from an all-zero packet so unused slots pad to 0.
            if (state_next == S_INFO && state != S_INFO) begin
                slot_col  <= '0;
                slot_val  <= '0;
                cap_cnt   <= '0;
                issue_cnt <= '0;
            end

            if (state == S_INFO_CAP) begin
                len_raw    <= info_len;
                row_info_q <= {info_len_sat, info_i[0]};
                if (info_len > MAX_LEN) begin
                    len_err <= 1'b1;
                end
            end

            // Pointer advances for every read, including those past the last
            // slot, so the next row stays aligned in element memory.
            if (state == S_ELEM) begin
                ptr       <= ptr + NNZ_ADDR_W'(1);
                issue_cnt <= issue_cnt + ROW_LEN_WIDTH'(1);
            end

            if (rd_d) begin
                if (cap_cnt < MAX_LEN) begin
                    slot_col[cap_cnt[COL_IDX_WIDTH-1:0]] <= elem_col_idx_i;
                    slot_val[cap_cnt[COL_IDX_WIDTH-1:0]] <= elem_value_i;
                end
                cap_cnt <= cap_cnt + ROW_LEN_WIDTH'(1);
            end

            if (state == S_OUT && row_ready_i && row_cnt != LAST_ROW) begin
                row_cnt <= row_cnt + ROW_ADDR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_csr_row_fetch.sv
// tb_csr_row_fetch
//   Scoreboard bench for csr_row_fetch. Models both memories with one-cycle
//   read latency, predicts every packet from the CSR contents at start, and
//   compares packets, done pulses, latency and error flag.
module tb_csr_row_fetch;
    localparam int DW  = 8;
    localparam int DPS = 5;
    localparam int H   = 5;
    localparam int NNZ = 64;
    localparam int CW  = $clog2(DPS);
    localparam int LW  = $clog2(DPS + 1);
    localparam int IW  = LW + 1;
    localparam int AW  = $clog2(NNZ);
    localparam int RW  = $clog2(H);

    logic                      clk;
    logic                      rst_n;
    logic                      start_i;
    logic                      info_rd_o;
    logic [RW-1:0]             info_addr_o;
    logic [IW-1:0]             info_i;
    logic                      elem_rd_o;
    logic [AW-1:0]             elem_addr_o;
    logic [CW-1:0]             elem_col_idx_i;
    logic [DW-1:0]             elem_value_i;
    logic                      row_valid_o;
    logic                      row_ready_i;
    logic [0:DPS-1][CW-1:0]    row_col_idx_o;
    logic [0:DPS-1][DW-1:0]    row_value_o;
    logic [IW-1:0]             row_info_o;
    logic [RW-1:0]             row_idx_o;
    logic                      done_o;
    logic                      len_err_o;

    csr_row_fetch #(
        .DATA_WIDTH(DW),
        .DOT_PRODUCT_SIZE(DPS),
        .H_NUM_OF_ROWS(H),
        .NNZ_DEPTH(NNZ)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start_i(start_i),
        .info_rd_o(info_rd_o),
        .info_addr_o(info_addr_o),
        .info_i(info_i),
        .elem_rd_o(elem_rd_o),
        .elem_addr_o(elem_addr_o),
        .elem_col_idx_i(elem_col_idx_i),
        .elem_value_i(elem_value_i),
        .row_valid_o(row_valid_o),
        .row_ready_i(row_ready_i),
        .row_col_idx_o(row_col_idx_o),
        .row_value_o(row_value_o),
        .row_info_o(row_info_o),
        .row_idx_o(row_idx_o),
        .done_o(done_o),
        .len_err_o(len_err_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [0:DPS-1][CW-1:0] col;
        logic [0:DPS-1][DW-1:0] val;
        logic [IW-1:0]          info;
        logic [RW-1:0]          idx;
    } pkt_t;

    pkt_t q[$];
    int   chk = 0;
    int   err = 0;
    bit   pend_done = 1'b0;

    logic [IW-1:0] info_mem [H];
    logic [CW-1:0] ecol     [NNZ];
    logic [DW-1:0] evalm    [NNZ];
    int            rdcnt    [NNZ];

    // Memory models: synchronous read, data valid the cycle after the address.
    always @(posedge clk) begin
        if (info_rd_o) info_i <= info_mem[info_addr_o];
        if (elem_rd_o) begin
            elem_col_idx_i <= ecol[elem_addr_o];
            elem_value_i   <= evalm[elem_addr_o];
            rdcnt[elem_addr_o] = rdcnt[elem_addr_o] + 1;
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        chk++;
        if (got !== want) begin
            err++;
            $display("FAIL %s got %0h expected %0h at %0t", name, got, want, $time);
        end
    endtask

    // Reference: walk CSR rows with a running element pointer.
    task automatic push_model();
        int unsigned ptr;
        int unsigned len;
        pkt_t p;
        ptr = 0;
        for (int r = 0; r < H; r++) begin
            len    = int'(info_mem[r][IW-1:1]);
            p.col  = '0;
            p.val  = '0;
            for (int k = 0; k < DPS; k++) begin
                if (k < len) begin
                    p.col[k] = ecol[(ptr + k) % NNZ];
                    p.val[k] = evalm[(ptr + k) % NNZ];
                end
            end
            p.info = {LW'((len > DPS) ? DPS : len), info_mem[r][0]};
            p.idx  = RW'(r);
            q.push_back(p);
            ptr = (ptr + len) % NNZ;
        end
    endtask

    function automatic bit model_len_err();
        bit e = 1'b0;
        for (int r = 0; r < H; r++) if (int'(info_mem[r][IW-1:1]) > DPS) e = 1'b1;
        return e;
    endfunction

    function automatic int model_elem_total();
        int s = 0;
        for (int r = 0; r < H; r++) s += int'(info_mem[r][IW-1:1]);
        return s;
    endfunction

    // Monitor: compares whatever packet is presented against the queue head.
    always @(negedge clk) begin
        if (rst_n) begin
            if (done_o || pend_done) check("done_pulse", 64'(done_o), 64'(pend_done));
            pend_done = 1'b0;
            if (row_valid_o) begin
                if (q.size() == 0) begin
                    check("unexpected_pkt", 64'(row_valid_o), 64'd0);
                end else begin
                    check("pkt_col",  64'(row_col_idx_o), 64'(q[0].col));
                    check("pkt_val",  64'(row_value_o),   64'(q[0].val));
                    check("pkt_info", 64'(row_info_o),    64'(q[0].info));
                    check("pkt_idx",  64'(row_idx_o),     64'(q[0].idx));
                    check("rd_while_valid", 64'({info_rd_o, elem_rd_o}), 64'd0);
                    if (row_ready_i) begin
                        if (q[0].idx == RW'(H - 1)) pend_done = 1'b1;
                        void'(q.pop_front());
                    end
                end
            end
        end
    end

    task automatic check_zero(input string name);
        logic any;
        any = |{info_rd_o, info_addr_o, elem_rd_o, elem_addr_o, row_valid_o,
                row_col_idx_o, row_value_o, row_info_o, row_idx_o, done_o, len_err_o};
        check(name, 64'(any), 64'd0);
    endtask

    task automatic clear_rdcnt();
        for (int a = 0; a < NNZ; a++) rdcnt[a] = 0;
    endtask

    task automatic load_lens(input int l0, input int l1, input int l2, input int l3, input int l4);
        int lens [H];
        lens = '{l0, l1, l2, l3, l4};
        for (int r = 0; r < H; r++) info_mem[r] = {LW'(lens[r]), 1'(r % 2)};
        for (int a = 0; a < NNZ; a++) begin
            ecol[a]  = CW'(a % DPS);
            evalm[a] = DW'(a * 7 + 3);
        end
    endtask

    task automatic load_random();
        for (int r = 0; r < H; r++) info_mem[r] = IW'($urandom_range(0, 2 ** IW - 1));
        for (int a = 0; a < NNZ; a++) begin
            ecol[a]  = CW'($urandom_range(0, DPS - 1));
            evalm[a] = DW'($urandom);
        end
    endtask

    // Issues start in IDLE and measures cycles until the first packet.
    task automatic do_start();
        int lat;
        int len0;
        len0 = int'(info_mem[0][IW-1:1]);
        push_model();
        clear_rdcnt();
        start_i = 1'b1;
        @(posedge clk);
        #1 start_i = 1'b0;
        check("len_err_cleared", 64'(len_err_o), 64'd0);
        lat = 1;
        while (!row_valid_o && lat < 100) begin
            @(posedge clk);
            #1 lat++;
        end
        check("first_valid_latency", 64'(lat), 64'((len0 == 0) ? 3 : 4 + len0));
    endtask

    // Runs until done_o; mode 0 ready=1, 1 random ready, 2 stall row 2 for
    // 10 cycles, 3 ready=1 with stray start pulses in ELEM and OUT.
    task automatic wait_done(input int mode);
        int  n;
        int  stall;
        bit  got_done;
        bit  pulsed_e;
        bit  pulsed_o;
        n = 0; stall = 10; got_done = 1'b0; pulsed_e = 1'b0; pulsed_o = 1'b0;
        while (!got_done && n < 2000) begin
            start_i = 1'b0;
            if (done_o) begin
                got_done = 1'b1;
            end else begin
                row_ready_i = 1'b1;
                if (mode == 1) row_ready_i = ($urandom_range(0, 2) != 0);
                if (mode == 2 && row_valid_o && row_idx_o == RW'(2) && stall > 0) begin
                    row_ready_i = 1'b0;
                    stall--;
                end
                if (mode == 3 && elem_rd_o && !pulsed_e) begin
                    start_i = 1'b1; pulsed_e = 1'b1;
                end
                if (mode == 3 && row_valid_o && row_idx_o == RW'(3) && !pulsed_o) begin
                    start_i = 1'b1; pulsed_o = 1'b1;
                end
                @(posedge clk);
                #1 n++;
            end
        end
        start_i     = 1'b0;
        row_ready_i = 1'b1;
        check("done_seen", 64'(got_done), 64'd1);
        check("len_err_final", 64'(len_err_o), 64'(model_len_err()));
        @(posedge clk);
        #1 check("queue_drained", 64'(q.size()), 64'd0);
        check("idle_after_done", 64'({row_valid_o, done_o}), 64'd0);
    endtask

    task automatic check_reads();
        int total;
        int bad;
        total = model_elem_total();
        bad = 0;
        for (int a = 0; a < NNZ; a++) if (rdcnt[a] != ((a < total) ? 1 : 0)) bad++;
        check("elem_reads_once", 64'(bad), 64'd0);
    endtask

    initial begin
        int n;
        rst_n       = 1'b0;
        start_i     = 1'b0;
        row_ready_i = 1'b1;
        clear_rdcnt();
        repeat (3) @(posedge clk);
        #1 check_zero("reset_outputs");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Mixed lengths, ready tied high.
        load_lens(2, 0, 5, 1, 3);
        do_start();
        wait_done(0);
        check_reads();

        // Same data with a 10-cycle stall on row 2.
        do_start();
        wait_done(2);
        check_reads();

        // Empty first row.
        load_lens(0, 3, 1, 0, 2);
        do_start();
        wait_done(0);

        // Over-long first row: length 7 saturates, pointer stays aligned.
        load_lens(7, 2, 1, 0, 3);
        do_start();
        wait_done(0);
        check_reads();

        // Stray start pulses in ELEM and OUT; following start clears len_err.
        do_start();
        wait_done(3);
        load_lens(1, 2, 3, 4, 5);
        do_start();
        wait_done(0);

        // Reset during ELEM of row 1, then a fresh run.
        load_lens(2, 3, 1, 4, 0);
        do_start();
        n = 0;
        while (!(row_idx_o == RW'(1) && elem_rd_o) && n < 200) begin
            @(posedge clk);
            #1 n++;
        end
        check("reached_row1_elem", 64'(n < 200), 64'd1);
        rst_n = 1'b0;
        #1 check_zero("midrun_reset_outputs");
        q.delete();
        pend_done = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        do_start();
        wait_done(0);
        check_reads();

        // Random CSR contents and random back-pressure.
        for (int run = 0; run < 8; run++) begin
            load_random();
            do_start();
            wait_done(1);
            check_reads();
        end

        $display("CHECKS %0d ERRORS %0d", chk, err);
        $finish;
    end

endmodule

// File: doc/csr_row_fetch.md
# csr_row_fetch

Upstream feeder for the sparse SPMM stage. Walks a CSR-encoded feature matrix H held in two synchronous-read memories (per-row info memory, per-nonzero element memory) and assembles one dense-slot row packet per H row: column indices, values and row info, zero-padded to DOT_PRODUCT_SIZE slots. It presents each packet on a valid/ready handshake to the sparse processing-element array, one row at a time in row order, and signals completion after the last row.

## Interface
- DATA_WIDTH, 8, width of a nonzero value
- DOT_PRODUCT_SIZE, 5, slots per row packet (= H column count)
- H_NUM_OF_ROWS, 5, rows fetched per start
- NNZ_DEPTH, 64, element memory depth
- COL_IDX_WIDTH, $clog2(DOT_PRODUCT_SIZE), column index width
- ROW_LEN_WIDTH, $clog2(DOT_PRODUCT_SIZE+1), row length width
- ROW_INFO_WIDTH, ROW_LEN_WIDTH+1, row info word: [ROW_INFO_WIDTH-1:1] = row length, [0] = source-node flag
- NNZ_ADDR_W, $clog2(NNZ_DEPTH); ROW_ADDR_W, $clog2(H_NUM_OF_ROWS)

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start_i  in  1  begin fetching rows 0..H_NUM_OF_ROWS-1; honoured only in IDLE
- info_rd_o  in→out  1  info memory read enable
- info_addr_o  out  ROW_ADDR_W  info memory address (registered)
- info_i  in  ROW_INFO_WIDTH  info memory data, valid one cycle after address
- elem_rd_o  out  1  element memory read enable
- elem_addr_o  out  NNZ_ADDR_W  element memory address (registered)
- elem_col_idx_i  in  COL_IDX_WIDTH  element column index, one-cycle latency
- elem_value_i  in  DATA_WIDTH  element value, one-cycle latency
- row_valid_o  out  1  packet valid
- row_ready_i  in  1  consumer accepts packet
- row_col_idx_o  out  COL_IDX_WIDTH × [0:DOT_PRODUCT_SIZE-1]  packed column indices
- row_value_o  out  DATA_WIDTH × [0:DOT_PRODUCT_SIZE-1]  packed values
- row_info_o  out  ROW_INFO_WIDTH  stored length + flag
- row_idx_o  out  ROW_ADDR_W  index of presented row
- done_o  out  1  one-cycle pulse after last handshake
- len_err_o  out  1  sticky: some row length exceeded DOT_PRODUCT_SIZE; cleared by start

## Operation
- States: IDLE → INFO (issue info read) → INFO_CAP (latch length/flag) → ELEM (issue L element reads) → ELEM_TAIL (capture last element) → OUT (hold valid) → INFO (next row) or DONE → IDLE.
- INFO_CAP with L = 0 goes directly to OUT.
- On start: row counter = 0, element pointer = 0, len_err_o cleared, all slots cleared.
- Element read issued in cycle c is written in cycle c+1 to slot k = (issue order within row); slots ≥ stored length stay 0 (col 0, value 0).
- Element pointer advances once per issued read for the full L, wraps modulo 2^NNZ_ADDR_W.
- L > DOT_PRODUCT_SIZE: all L elements read (pointer stays aligned), only first DOT_PRODUCT_SIZE stored, row_info_o length saturates to DOT_PRODUCT_SIZE, len_err_o set.
- Source-node flag passed through unchanged.
- Slots are cleared on entry to INFO for each row.
- start_i outside IDLE ignored.
- No prefetch: next row's INFO begins only after handshake.

## Timing
- t0 = cycle start_i high in IDLE. INFO at t0+1, INFO_CAP at t0+2, ELEM t0+3..t0+2+L, ELEM_TAIL t0+3+L, row_valid_o high from t0+4+L (L > 0) or t0+3 (L = 0).
- Handshake at cycle h (valid && ready): row_valid_o low at h+1; next row follows the same offsets with h in place of t0.
- While row_valid_o && !row_ready_i: all row_* outputs stable, info_rd_o = elem_rd_o = 0.
- Last-row handshake at h: done_o = 1 at h+1 (DONE), IDLE at h+2.
- Reset: every output 0 asynchronously (row_valid_o, done_o, len_err_o, addresses, rd enables, all slots); state IDLE; mid-operation reset abandons the row, no done_o.

## Test plan
- Lengths {2,0,5,1,3}, ready tied 1, distinct values → five packets in order, row 0 valid at t0+6, padding zero, one done_o pulse, element addresses 0..10 each read once.
- Same data, row_ready_i low 10 cycles during row 2 → packet stable, no reads issued, resumes correctly.
- Row 0 length 0 → valid at t0+3, all slots 0, row_info_o length 0.
- DOT_PRODUCT_SIZE=5, row length 7 → 5 slots stored, length 5 reported, len_err_o = 1, next row's first read at pointer 7.
- rst_n asserted during ELEM of row 1 → outputs zero immediately; fresh start reproduces row 0 exactly.
- start_i pulsed in OUT and ELEM → ignored, sequence unchanged; start after DONE refetches from row 0, len_err_o cleared.
